// File: rtl/gayle_pkg.sv
// Shared types and constants for the Gayle IDE CPU bus front end.
package gayle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOLD,
      ST_STROBE,
      ST_CAPTURE,
      ST_ACK
   } state_t;

   localparam logic [1:0] GREG_CS    = 2'd0;
   localparam logic [1:0] GREG_IRQ   = 2'd1;
   localparam logic [1:0] GREG_INTEN = 2'd2;
   localparam logic [1:0] GREG_CFG   = 2'd3;

   localparam logic [3:0] TF_DATA    = 4'd0;
   localparam logic [3:0] TF_STATUS  = 4'd7;
   localparam logic [3:0] TF_DEVCTRL = 4'd14;

   localparam logic [7:0] GAYLE_ID_DEFAULT = 8'hD0;

endpackage

// File: rtl/gayle_regs.sv
// Gayle control registers (IRQ status, interrupt enable, config), serial ID register
// and the read mux feeding cpu_dout for the Gayle and ID windows.
module gayle_regs
   import gayle_pkg::*;
#(
   parameter logic [7:0] GAYLE_ID = GAYLE_ID_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ide_irq,
   input  logic        gayle_acc,
   input  logic        id_acc,
   input  logic        wr,
   input  logic [1:0]  reg_sel,
   input  logic [15:0] din,
   output logic [15:0] rdata,
   output logic        int2
);

   logic       irq_q;
   logic       irq_chg;
   logic       int_en;
   logic [3:0] cfg;
   logic [2:0] id_cnt;
   logic       irq_rise;

   assign irq_rise = ide_irq & ~irq_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q   <= 1'b0;
         irq_chg <= 1'b0;
         int_en  <= 1'b0;
         cfg     <= 4'h0;
         id_cnt  <= 3'd0;
         int2    <= 1'b0;
      end else begin
         irq_q <= ide_irq;
         int2  <= irq_chg & int_en;
         if (gayle_acc && wr) begin
            case (reg_sel)
               GREG_IRQ:   irq_chg <= irq_chg & din[15];
               GREG_INTEN: int_en  <= din[15];
               GREG_CFG:   cfg     <= din[15:12];
               default:    ;
            endcase
         end
         // a new interrupt edge must never be lost to a clearing write in the same cycle
         if (irq_rise)
            irq_chg <= 1'b1;
         if (id_acc)
            id_cnt <= wr ? 3'd0 : id_cnt + 3'd1;
      end
   end

   always_comb begin
      rdata = 16'h0000;
      if (id_acc) begin
         rdata[15] = GAYLE_ID[3'd7 - id_cnt];
      end else begin
         case (reg_sel)
            GREG_CS:    rdata[15]    = ide_irq;
            GREG_IRQ:   rdata[15]    = irq_chg;
            GREG_INTEN: rdata[15]    = int_en;
            default:    rdata[15:12] = cfg;
         endcase
      end
   end

endmodule

// File: rtl/gayle_ide_bus.sv
// Gayle-style CPU bus front end: task-file strobes, DTACK stretching, Gayle registers, INT2.
// Optional macro GAYLE_TIMEOUT_EN aborts accesses held longer than WAIT_TIMEOUT cycles.
//
// state   | meaning
// IDLE    | waiting for a cpu_as rising edge
// HOLD    | task file busy or read data not ready; CPU cycle stretched
// STROBE  | one-cycle io_read / io_write
// CAPTURE | task-file read data latched into cpu_dout
// ACK     | cpu_dtack high until cpu_as falls
module gayle_ide_bus
   import gayle_pkg::*;
#(
   parameter int         WAIT_TIMEOUT = 1023,
   parameter logic [7:0] GAYLE_ID     = GAYLE_ID_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_as,
   input  logic        cpu_rw,
   input  logic [11:0] cpu_addr,
   input  logic [15:0] cpu_din,
   output logic [15:0] cpu_dout,
   output logic        cpu_dtack,
   input  logic        sel_ide,
   input  logic        sel_gayle,
   input  logic        sel_id,
   output logic [3:0]  io_address,
   output logic        io_read,
   output logic        io_write,
   output logic [31:0] io_writedata,
   output logic        io_32,
   input  logic [31:0] io_readdata,
   input  logic        io_wait,
   input  logic        no_data,
   input  logic        ide_irq,
   output logic        int2
);

   localparam logic [9:0] HOLD_LIMIT = 10'(WAIT_TIMEOUT - 1);

   state_t      state;
   logic        as_q;
   logic        rw_q;
   logic        as_rise;
   logic        start;
   logic        hold_start;
   logic        hold_now;
   logic [3:0]  idx;
   logic        gayle_acc;
   logic        id_acc;
   logic [15:0] reg_rdata;

   assign io_32      = 1'b0;
   assign as_rise    = cpu_as & ~as_q;
   assign start      = (state == ST_IDLE) & as_rise;
   assign idx        = {cpu_addr[10], cpu_addr[2:0]};
   assign hold_start = io_wait | (cpu_rw & (idx == TF_DATA) & no_data);
   assign hold_now   = io_wait | (rw_q & (io_address == TF_DATA) & no_data);
   assign gayle_acc  = start & ~sel_ide & sel_gayle;
   assign id_acc     = start & ~sel_ide & ~sel_gayle & sel_id;

`ifdef GAYLE_TIMEOUT_EN
   logic [9:0] hold_cnt;
   wire unused_bits = ^{cpu_addr[9:3], io_readdata[31:16]};
`else
   wire unused_bits = ^{cpu_addr[9:3], io_readdata[31:16], HOLD_LIMIT};
`endif

   gayle_regs #(.GAYLE_ID(GAYLE_ID)) u_regs (
      .clk       (clk),
      .reset     (reset),
      .ide_irq   (ide_irq),
      .gayle_acc (gayle_acc),
      .id_acc    (id_acc),
      .wr        (~cpu_rw),
      .reg_sel   (cpu_addr[11:10]),
      .din       (cpu_din),
      .rdata     (reg_rdata),
      .int2      (int2)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         as_q         <= 1'b0;
         rw_q         <= 1'b0;
         cpu_dout     <= 16'h0000;
         cpu_dtack    <= 1'b0;
         io_address   <= 4'h0;
         io_read      <= 1'b0;
         io_write     <= 1'b0;
         io_writedata <= 32'h0;
`ifdef GAYLE_TIMEOUT_EN
         hold_cnt     <= 10'd0;
`endif
      end else begin
         as_q     <= cpu_as;
         io_read  <= 1'b0;
         io_write <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (as_rise && sel_ide) begin
                  rw_q         <= cpu_rw;
                  io_address   <= idx;
                  io_writedata <= (idx == TF_DATA) ? {16'h0, cpu_din} : {24'h0, cpu_din[15:8]};
                  if (hold_start) begin
                     state <= ST_HOLD;
`ifdef GAYLE_TIMEOUT_EN
                     hold_cnt <= HOLD_LIMIT;
`endif
                  end else begin
                     state    <= ST_STROBE;
                     io_read  <= cpu_rw;
                     io_write <= ~cpu_rw;
                  end
               end else if (as_rise && (sel_gayle || sel_id)) begin
                  cpu_dout  <= reg_rdata;
                  cpu_dtack <= 1'b1;
                  state     <= ST_ACK;
               end
            end
            ST_HOLD: begin
               if (!cpu_as) begin
                  state <= ST_IDLE;
               end else if (!hold_now) begin
                  state    <= ST_STROBE;
                  io_read  <= rw_q;
                  io_write <= ~rw_q;
               end
`ifdef GAYLE_TIMEOUT_EN
               else if (hold_cnt == 10'd0) begin
                  cpu_dout  <= 16'hFFFF;
                  cpu_dtack <= 1'b1;
                  state     <= ST_ACK;
               end else begin
                  hold_cnt <= hold_cnt - 10'd1;
               end
`endif
            end
            ST_STROBE: begin
               state <= cpu_as ? ST_CAPTURE : ST_IDLE;
            end
            ST_CAPTURE: begin
               if (!cpu_as) begin
                  state <= ST_IDLE;
               end else begin
                  if (rw_q)
                     cpu_dout <= (io_address == TF_DATA) ? io_readdata[15:0]
                                                         : {io_readdata[7:0], io_readdata[7:0]};
                  cpu_dtack <= 1'b1;
                  state     <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (!cpu_as) begin
                  cpu_dtack <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gayle_ide_bus.sv
// Self-checking bench for gayle_ide_bus: directed and randomized bus cycles against a
// behavioural model of the task-file front end and the Gayle registers.
module tb_gayle_ide_bus;
   import gayle_pkg::*;

`ifdef GAYLE_TIMEOUT_EN
   localparam int HOLD_LEN  = 10;
   localparam int MAX_STALL = 8;
`else
   localparam int HOLD_LEN  = 20;
   localparam int MAX_STALL = 12;
`endif
   localparam logic [7:0] ID_VAL = 8'hD0;

   logic        clk, reset;
   logic        cpu_as, cpu_rw;
   logic [11:0] cpu_addr;
   logic [15:0] cpu_din, cpu_dout;
   logic        cpu_dtack;
   logic        sel_ide, sel_gayle, sel_id;
   logic [3:0]  io_address;
   logic        io_read, io_write, io_32;
   logic [31:0] io_writedata, io_readdata;
   logic        io_wait, no_data, ide_irq, int2;

   int n_vec = 0;
   int n_err = 0;
   int rd_pulses = 0;
   int wr_pulses = 0;
   logic [3:0]  last_addr = 4'h0;
   logic [31:0] last_wdata = 32'h0;

   logic       m_irq, m_inten;
   logic [3:0] m_cfg;
   int         m_id;

   gayle_ide_bus #(.WAIT_TIMEOUT(16), .GAYLE_ID(ID_VAL)) dut (
      .clk(clk), .reset(reset), .cpu_as(cpu_as), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_dtack(cpu_dtack), .sel_ide(sel_ide),
      .sel_gayle(sel_gayle), .sel_id(sel_id), .io_address(io_address), .io_read(io_read),
      .io_write(io_write), .io_writedata(io_writedata), .io_32(io_32), .io_readdata(io_readdata),
      .io_wait(io_wait), .no_data(no_data), .ide_irq(ide_irq), .int2(int2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // task-file side monitor: counts strobes and remembers what each one carried
   always @(posedge clk) begin
      if (io_read)  rd_pulses <= rd_pulses + 1;
      if (io_write) wr_pulses <= wr_pulses + 1;
      if (io_read || io_write) begin
         last_addr  <= io_address;
         last_wdata <= io_writedata;
      end
   end

   task automatic release_bus();
      int cyc;
      cpu_as = 0; sel_ide = 0; sel_gayle = 0; sel_id = 0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (cpu_dtack !== 1'b0 && cyc < 50);
      n_vec++;
      if (cpu_dtack !== 1'b0) begin
         n_err++; $display("FAIL dtack_release: dtack=%b, want 0", cpu_dtack);
      end
      @(negedge clk);
   endtask

   task automatic tf_access(input bit rw, input logic [11:0] addr, input logic [15:0] din,
                            input logic [31:0] rdata, input int stall, input bit nd_stall,
                            input bit both_sel, input string tag);
      logic [3:0]  idx;
      logic [15:0] exp_dout;
      logic [31:0] exp_wd;
      int eff, cyc, rp0, wp0;
      idx      = {addr[10], addr[2:0]};
      eff      = (stall == 0) ? 0 : (!nd_stall ? stall : ((rw && idx == 4'd0) ? stall : 0));
      exp_dout = (idx == 4'd0) ? rdata[15:0] : {rdata[7:0], rdata[7:0]};
      exp_wd   = (idx == 4'd0) ? {16'h0, din} : {24'h0, din[15:8]};
      rp0 = rd_pulses; wp0 = wr_pulses;
      cpu_rw = rw; cpu_addr = addr; cpu_din = din; sel_ide = 1; sel_gayle = both_sel;
      io_readdata = (nd_stall && eff > 0) ? ~rdata : rdata;
      io_wait = (stall > 0) && !nd_stall;
      no_data = (stall > 0) && nd_stall;
      cpu_as = 1;
      cyc = 0;
      while (cpu_dtack !== 1'b1 && cyc < 200) begin
         @(negedge clk); cyc++;
         if (cyc == stall) begin io_wait = 0; no_data = 0; io_readdata = rdata; end
      end
      io_wait = 0; no_data = 0;
      n_vec++;
      if (cyc != eff + 3) begin
         n_err++; $display("FAIL tf_latency[%s]: %0d cycles, want %0d", tag, cyc, eff + 3);
      end
      n_vec++;
      if ((rd_pulses - rp0) != int'(rw) || (wr_pulses - wp0) != int'(!rw)) begin
         n_err++;
         $display("FAIL tf_strobes[%s]: reads=%0d writes=%0d, want rw=%0d", tag,
                  rd_pulses - rp0, wr_pulses - wp0, rw);
      end
      n_vec++;
      if (last_addr !== idx) begin
         n_err++; $display("FAIL tf_address[%s]: %0d, want %0d", tag, last_addr, idx);
      end
      n_vec++;
      if (rw && cpu_dout !== exp_dout) begin
         n_err++; $display("FAIL tf_rdata[%s]: %h, want %h", tag, cpu_dout, exp_dout);
      end else if (!rw && last_wdata !== exp_wd) begin
         n_err++; $display("FAIL tf_wdata[%s]: %h, want %h", tag, last_wdata, exp_wd);
      end
      release_bus();
   endtask

   task automatic g_access(input bit rw, input bit is_id, input logic [1:0] rsel,
                           input logic [15:0] din, output logic [15:0] dout);
      int cyc;
      cpu_rw = rw; cpu_addr = {rsel, 10'h0}; cpu_din = din;
      sel_ide = 0; sel_gayle = !is_id; sel_id = is_id;
      cpu_as = 1;
      cyc = 0;
      while (cpu_dtack !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      dout = cpu_dout;
      n_vec++;
      if (cyc != 1) begin
         n_err++; $display("FAIL g_latency: %0d cycles, want 1", cyc);
      end
      release_bus();
   endtask

   task automatic g_write(input logic [1:0] rsel, input logic [15:0] din);
      logic [15:0] d;
      case (rsel)
         GREG_IRQ:   m_irq   = m_irq & din[15];
         GREG_INTEN: m_inten = din[15];
         GREG_CFG:   m_cfg   = din[15:12];
         default:    ;
      endcase
      g_access(1'b0, 1'b0, rsel, din, d);
   endtask

   task automatic g_read(input logic [1:0] rsel, input string tag);
      logic [15:0] d, exp;
      case (rsel)
         GREG_CS:    exp = {ide_irq, 15'h0};
         GREG_IRQ:   exp = {m_irq, 15'h0};
         GREG_INTEN: exp = {m_inten, 15'h0};
         default:    exp = {m_cfg, 12'h0};
      endcase
      g_access(1'b1, 1'b0, rsel, 16'h0, d);
      n_vec++;
      if (d !== exp) begin
         n_err++; $display("FAIL g_read[%s]: %h, want %h", tag, d, exp);
      end
   endtask

   task automatic check_int2(input string tag);
      n_vec++;
      if (int2 !== (m_irq & m_inten)) begin
         n_err++; $display("FAIL int2[%s]: %b, want %b", tag, int2, m_irq & m_inten);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      logic [56:0] obs;
      obs = {cpu_dout, cpu_dtack, io_address, io_read, io_write, io_writedata, io_32, int2};
      n_vec++;
      if (obs !== 57'h0) begin
         n_err++; $display("FAIL reset_outputs[%s]: %h, want 0", tag, obs);
      end
   endtask

   task automatic test_reset();
      reset = 1; cpu_as = 0; cpu_rw = 0; cpu_addr = 0; cpu_din = 0;
      sel_ide = 0; sel_gayle = 0; sel_id = 0; io_readdata = 0;
      io_wait = 0; no_data = 0; ide_irq = 0;
      m_irq = 0; m_inten = 0; m_cfg = 0; m_id = 0;
      repeat (3) @(negedge clk);
      check_idle_outputs("in_reset");
      reset = 0;
      repeat (2) @(negedge clk);
      check_idle_outputs("after_reset");
   endtask

   task automatic test_directed_tf();
      tf_access(1, 12'h807, 16'h0000, 32'h0000_0050, 0, 0, 0, "status_read");
      n_vec++;
      if (last_addr !== TF_STATUS) begin
         n_err++; $display("FAIL status_index: %0d, want %0d", last_addr, TF_STATUS);
      end
      tf_access(0, 12'h807, 16'hEC00, 32'h0, HOLD_LEN, 0, 0, "hold_write");
      tf_access(0, 12'h406, 16'h0200, 32'h0, 0, 0, 0, "devctrl_write");
      n_vec++;
      if (last_addr !== TF_DEVCTRL) begin
         n_err++; $display("FAIL devctrl_index: %0d, want %0d", last_addr, TF_DEVCTRL);
      end
      tf_access(1, 12'h000, 16'h0000, 32'h1234_ABCD, 5, 1, 0, "nodata_read");
   endtask

   task automatic test_random_tf();
      for (int i = 0; i < 30; i++) begin
         logic [11:0] a;
         int st;
         a  = 12'($urandom);
         if ($urandom_range(0, 2) == 0) begin a[10] = 1'b0; a[2:0] = 3'd0; end
         st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, MAX_STALL)) : 0;
         tf_access(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom, st,
                   1'($urandom_range(0, 1)), 0, "random");
      end
   endtask

   task automatic test_priority();
      tf_access(1, 12'h403, 16'h0, 32'h0000_00A5, 0, 0, 1, "ide_over_gayle");
      tf_access(0, 12'h000, 16'h5A3C, 32'h0, 2, 0, 1, "ide_over_gayle_wr");
   endtask

   task automatic test_abort();
      int rp0, wp0;
      rp0 = rd_pulses; wp0 = wr_pulses;
      cpu_rw = 0; cpu_addr = 12'h805; cpu_din = 16'h1100; sel_ide = 1; io_wait = 1; cpu_as = 1;
      repeat (5) @(negedge clk);
      cpu_as = 0; sel_ide = 0;
      repeat (3) @(negedge clk);
      io_wait = 0;
      repeat (4) @(negedge clk);
      n_vec++;
      if (rd_pulses != rp0 || wr_pulses != wp0 || cpu_dtack !== 1'b0) begin
         n_err++;
         $display("FAIL abort_hold: strobes=%0d dtack=%b, want 0 and 0",
                  (rd_pulses - rp0) + (wr_pulses - wp0), cpu_dtack);
      end
   endtask

   task automatic test_irq();
      ide_irq = 0; repeat (2) @(negedge clk);
      g_write(GREG_INTEN, 16'h8000);
      g_write(GREG_IRQ, 16'h0000);
      ide_irq = 1; m_irq = 1;
      repeat (3) @(negedge clk);
      check_int2("irq_raise");
      g_read(GREG_IRQ, "irq_set");
      g_read(GREG_CS, "cs_level");
      g_write(GREG_IRQ, 16'h0000);
      repeat (2) @(negedge clk);
      check_int2("irq_clear");
      g_read(GREG_IRQ, "irq_cleared");
      ide_irq = 0; repeat (2) @(negedge clk);
      ide_irq = 1;
      g_write(GREG_IRQ, 16'h0000);
      m_irq = 1;
      repeat (2) @(negedge clk);
      g_read(GREG_IRQ, "set_beats_clear");
      check_int2("set_beats_clear");
   endtask

   task automatic test_id();
      logic [15:0] d, exp;
      logic [7:0]  idv;
      idv = ID_VAL;
      g_access(1'b0, 1'b1, 2'd0, 16'h0, d);
      m_id = 0;
      for (int i = 0; i < 9; i++) begin
         g_access(1'b1, 1'b1, 2'd0, 16'h0, d);
         exp  = {1'((idv >> (7 - m_id)) & 8'h1), 15'h0};
         m_id = (m_id + 1) % 8;
         n_vec++;
         if (d !== exp) begin
            n_err++; $display("FAIL id_bit[%0d]: %h, want %h", i, d, exp);
         end
      end
   endtask

   task automatic test_random_regs();
      for (int i = 0; i < 24; i++) begin
         logic [1:0]  rs;
         logic [15:0] din, d, exp;
         logic [7:0]  idv;
         idv = ID_VAL;
         rs  = 2'($urandom_range(0, 3));
         din = 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               g_access(1'b0, 1'b1, rs, din, d);
               m_id = 0;
            end else begin
               g_access(1'b1, 1'b1, rs, 16'h0, d);
               exp  = {1'((idv >> (7 - m_id)) & 8'h1), 15'h0};
               m_id = (m_id + 1) % 8;
               n_vec++;
               if (d !== exp) begin
                  n_err++; $display("FAIL id_random[%0d]: %h, want %h", i, d, exp);
               end
            end
         end else if ($urandom_range(0, 1) == 1) begin
            g_write(rs, din);
         end else begin
            g_read(rs, "random");
         end
         check_int2("random");
      end
   endtask

`ifdef GAYLE_TIMEOUT_EN
   task automatic test_timeout();
      int rp0, wp0, cyc;
      rp0 = rd_pulses; wp0 = wr_pulses;
      cpu_rw = 1; cpu_addr = 12'h807; sel_ide = 1; io_wait = 1; cpu_as = 1;
      cyc = 0;
      while (cpu_dtack !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
      n_vec++;
      if (cyc < 15 || cyc > 20 || cpu_dout !== 16'hFFFF || rd_pulses != rp0 || wr_pulses != wp0) begin
         n_err++;
         $display("FAIL timeout: cycles=%0d dout=%h strobes=%0d, want ~17, ffff, 0",
                  cyc, cpu_dout, (rd_pulses - rp0) + (wr_pulses - wp0));
      end
      io_wait = 0;
      release_bus();
   endtask
`endif

   task automatic test_reset_mid();
      int rp0;
      ide_irq = 0;
      rp0 = rd_pulses;
      cpu_rw = 1; cpu_addr = 12'h807; sel_ide = 1; io_wait = 1; cpu_as = 1;
      repeat (4) @(negedge clk);
      reset = 1; cpu_as = 0; sel_ide = 0;
      #1;
      check_idle_outputs("mid_access");
      m_irq = 0; m_inten = 0; m_cfg = 0; m_id = 0;
      @(negedge clk);
      reset = 0; io_wait = 0;
      repeat (5) @(negedge clk);
      n_vec++;
      if (rd_pulses != rp0 || cpu_dtack !== 1'b0) begin
         n_err++;
         $display("FAIL reset_drop: reads=%0d dtack=%b, want 0 and 0", rd_pulses - rp0, cpu_dtack);
      end
      g_read(GREG_INTEN, "after_reset");
      tf_access(1, 12'h807, 16'h0, 32'h0000_0041, 0, 0, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed_tf();
      test_random_tf();
      test_priority();
      test_abort();
      test_irq();
      test_id();
      test_random_regs();
`ifdef GAYLE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
